// File: rtl/screen_write_arbiter_if.sv
// Write-port bundle between the image generator / CPU sources and the screen memory.
interface screen_write_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();

  logic [ADDR_W-1:0] gen_address;
  logic              gen_load;
  logic [DATA_W-1:0] gen_out;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_gnt;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_load;
  logic [DATA_W-1:0] mem_data;

  // Source side: drives the generator stream and CPU request, observes grant and memory port.
  modport master (
    output gen_address, gen_load, gen_out,
    output cpu_req, cpu_address, cpu_data,
    input  cpu_gnt,
    input  mem_address, mem_load, mem_data
  );

  // Arbiter side.
  modport slave (
    input  gen_address, gen_load, gen_out,
    input  cpu_req, cpu_address, cpu_data,
    output cpu_gnt,
    output mem_address, mem_load, mem_data
  );

endinterface

// File: rtl/screen_write_arbiter.sv
// Screen memory write-port arbiter: generator writes are buffered in a small FIFO and
// drained one per cycle; CPU writes use req/gnt with a bounded wait before a forced grant.
module screen_write_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  screen_write_arbiter_if.slave         bus,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_GEN  = 2'd1;
  localparam logic [1:0] SEL_CPU  = 2'd2;

  entry_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [WAIT_W-1:0]   wait_cnt;

  logic [1:0]          sel_c;
  logic                fifo_empty_c;
  logic                fifo_full_c;
  logic                wait_max_c;
  logic                pop_c;
  logic                push_c;
  logic                drop_c;
  entry_t              head_c;

  // Source selection: forced CPU grant, then FIFO drain, then idle-time CPU grant.
  always_comb begin
    sel_c        = SEL_NONE;
    fifo_empty_c = (fifo_level == '0);
    fifo_full_c  = (fifo_level == LVL_W'(FIFO_DEPTH));
    wait_max_c   = (wait_cnt == WAIT_W'(MAX_WAIT));
    head_c       = fifo_mem[rd_ptr];
    if (bus.cpu_req && wait_max_c) begin
      sel_c = SEL_CPU;
    end else if (!fifo_empty_c) begin
      sel_c = SEL_GEN;
    end else if (bus.cpu_req) begin
      sel_c = SEL_CPU;
    end
    pop_c  = (sel_c == SEL_GEN);
    push_c = bus.gen_load && (!fifo_full_c || pop_c);
    drop_c = bus.gen_load && !push_c;
  end

  assign bus.cpu_gnt = (sel_c == SEL_CPU);

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= entry_t'({bus.gen_address, bus.gen_out});
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // CPU starvation counter: counts denied request cycles, saturating at the forced-grant point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!bus.cpu_req || bus.cpu_gnt) begin
      wait_cnt <= '0;
    end else if (!wait_max_c) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Registered memory write port; address/data hold when nothing is selected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_load    <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_data    <= '0;
    end else begin
      bus.mem_load <= (sel_c != SEL_NONE);
      if (sel_c == SEL_GEN) begin
        bus.mem_address <= head_c.addr;
        bus.mem_data    <= head_c.data;
      end else if (sel_c == SEL_CPU) begin
        bus.mem_address <= bus.cpu_address;
        bus.mem_data    <= bus.cpu_data;
      end
    end
  end

  // Sticky drop flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Bench for screen_write_arbiter: a queue-based reference pushes expected memory writes
// at each edge and a negedge monitor pops and compares them; tasks add directed checks.
module tb_screen_write_arbiter;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MAX_WAIT   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [2:0] fifo_level;
  logic       overflow;

  screen_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  screen_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .clear_overflow(clear_overflow),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_fifo [$];
  logic [31:0] exp_q  [$];
  logic [15:0] obs_q  [$];
  int          m_wait = 0;
  logic        m_ovf  = 1'b0;
  logic [15:0] gen_next = 16'h0;
  int          sent = 0;

  // Reference: decide the winner from the reference state, queue the expected write.
  always @(posedge clk) begin : model
    logic cpu_sel, gen_sel, dropped;
    if (reset) begin
      cpu_sel = bus.cpu_req && ((m_wait == int'(MAX_WAIT)) || (m_fifo.size() == 0));
      gen_sel = !cpu_sel && (m_fifo.size() != 0);
      dropped = 1'b0;
      if (gen_sel) exp_q.push_back(m_fifo.pop_front());
      if (cpu_sel) exp_q.push_back({bus.cpu_address, bus.cpu_data});
      if (bus.gen_load) begin
        if (m_fifo.size() < int'(FIFO_DEPTH)) m_fifo.push_back({bus.gen_address, bus.gen_out});
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      if (!bus.cpu_req || cpu_sel) m_wait = 0;
      else if (m_wait < int'(MAX_WAIT)) m_wait = m_wait + 1;
    end
  end

  always @(negedge reset) begin
    m_fifo.delete();
    exp_q.delete();
    m_wait = 0;
    m_ovf  = 1'b0;
  end

  // Scoreboard monitor: every cycle the memory port must match the queued expectation.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (reset) begin
      n_checks++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (bus.mem_load !== 1'b1 || bus.mem_address !== e[31:16] || bus.mem_data !== e[15:0]) begin
          n_fail++;
          $display("FAIL mem_write: got load=%b addr=%h data=%h, want load=1 addr=%h data=%h",
                   bus.mem_load, bus.mem_address, bus.mem_data, e[31:16], e[15:0]);
        end
      end else if (bus.mem_load !== 1'b0) begin
        n_fail++;
        $display("FAIL mem_idle: got load=%b addr=%h, want load=0", bus.mem_load, bus.mem_address);
      end
      if (bus.mem_load === 1'b1) obs_q.push_back(bus.mem_address);
      n_checks++;
      if (fifo_level !== 3'(m_fifo.size())) begin
        n_fail++;
        $display("FAIL level_track: got %0d, want %0d", fifo_level, m_fifo.size());
      end
      n_checks++;
      if (overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL ovf_track: got %b, want %b", overflow, m_ovf);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_drive(input logic en);
    bus.gen_load = en;
    if (en) begin
      bus.gen_address = gen_next;
      bus.gen_out     = ~gen_next;
      gen_next        = gen_next + 16'd1;
      sent++;
    end
  endtask

  task automatic test_reset();
    bus.gen_load = 1'b0; bus.gen_address = '0; bus.gen_out = '0;
    bus.cpu_req = 1'b0; bus.cpu_address = '0; bus.cpu_data = '0;
    #2;
    n_checks++;
    if (bus.mem_load !== 1'b0 || bus.mem_address !== 16'h0 || bus.mem_data !== 16'h0 ||
        overflow !== 1'b0 || fifo_level !== 3'd0 || bus.cpu_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got load=%b addr=%h data=%h ovf=%b lvl=%0d gnt=%b, want all 0",
               bus.mem_load, bus.mem_address, bus.mem_data, overflow, fifo_level, bus.cpu_gnt);
    end
    bus.cpu_req = 1'b1;
    #1;
    n_checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b, want 1", bus.cpu_gnt);
    end
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_gen();
    bus.gen_load = 1'b1; bus.gen_address = 16'h4000; bus.gen_out = 16'hFFFF;
    @(posedge clk);
    #1 bus.gen_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_load !== 1'b0 || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL gen_e0: got load=%b lvl=%0d, want load=0 lvl=1", bus.mem_load, fifo_level);
    end
    @(negedge clk);
    n_checks++;
    if (bus.mem_load !== 1'b1 || bus.mem_address !== 16'h4000 || bus.mem_data !== 16'hFFFF || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL gen_e1: got load=%b addr=%h data=%h lvl=%0d, want 1/4000/ffff/0",
               bus.mem_load, bus.mem_address, bus.mem_data, fifo_level);
    end
    @(negedge clk);
    n_checks++;
    if (bus.mem_load !== 1'b0) begin
      n_fail++;
      $display("FAIL gen_e2: got load=%b, want 0", bus.mem_load);
    end
    next_cycle();
  endtask

  task automatic test_cpu_alone();
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h1234; bus.cpu_data = 16'hA5A5;
    #1;
    n_checks++;
    if (bus.cpu_gnt !== 1'b1 || dut.wait_cnt !== '0) begin
      n_fail++;
      $display("FAIL cpu_gnt: got gnt=%b wait=%0d, want gnt=1 wait=0", bus.cpu_gnt, dut.wait_cnt);
    end
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_load !== 1'b1 || bus.mem_address !== 16'h1234 || bus.mem_data !== 16'hA5A5 || dut.wait_cnt !== '0) begin
      n_fail++;
      $display("FAIL cpu_write: got load=%b addr=%h data=%h wait=%0d, want 1/1234/a5a5/0",
               bus.mem_load, bus.mem_address, bus.mem_data, dut.wait_cnt);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      bus.cpu_req = 1'b1; bus.cpu_address = 16'h2000 + 16'(i); bus.cpu_data = 16'h3C00 + 16'(i);
      #1;
      n_checks++;
      if (bus.cpu_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_gnt[%0d]: got %b, want 1", i, bus.cpu_gnt);
      end
      next_cycle();
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_load !== 1'b1 || bus.mem_address !== 16'h2002 || bus.mem_data !== 16'h3C02) begin
      n_fail++;
      $display("FAIL b2b_last: got load=%b addr=%h data=%h, want 1/2002/3c02",
               bus.mem_load, bus.mem_address, bus.mem_data);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    gen_next = 16'h6000;
    gen_drive(1'b1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      gen_drive(1'b1);
    end
    @(negedge clk);
    n_checks++;
    if (fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL stream_level: got %0d, want 1", fifo_level);
    end
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h0ABC; bus.cpu_data = 16'h1111;
    for (int c = 0; c <= int'(MAX_WAIT); c++) begin
      #1;
      n_checks++;
      if (bus.cpu_gnt !== (c == int'(MAX_WAIT))) begin
        n_fail++;
        $display("FAIL starve_gnt[%0d]: got %b, want %b", c, bus.cpu_gnt, (c == int'(MAX_WAIT)));
      end
      @(posedge clk);
      #1;
      gen_drive(1'b1);
      if (c == int'(MAX_WAIT)) bus.cpu_req = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (fifo_level !== 3'd2) begin
      n_fail++;
      $display("FAIL starve_level: got %0d, want 2", fifo_level);
    end
    bus.gen_load = 1'b0;
    repeat (6) next_cycle();
    n_checks++;
    if (fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL starve_drain: got %0d, want 0", fifo_level);
    end
  endtask

  task automatic test_overflow();
    int grants;
    int found;
    logic g;
    obs_q.delete();
    gen_next = 16'h8000;
    sent = 0;
    grants = 0;
    gen_drive(1'b1);
    next_cycle();
    gen_drive(1'b1);
    next_cycle();
    gen_drive(1'b1);
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h0C00; bus.cpu_data = 16'h5000;
    for (int cyc = 0; cyc < 80 && grants < 4; cyc++) begin
      @(negedge clk);
      g = (bus.cpu_gnt === 1'b1);
      if (g) begin
        grants++;
        if (grants == 4) clear_overflow = 1'b1;
      end
      @(posedge clk);
      #1;
      if (g) begin
        n_checks++;
        if (grants < 4) begin
          if (fifo_level !== 3'(grants + 1) || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_grant%0d: got lvl=%0d ovf=%b, want lvl=%0d ovf=0",
                     grants, fifo_level, overflow, grants + 1);
          end
        end else if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_drop: got lvl=%0d ovf=%b, want lvl=4 ovf=1", fifo_level, overflow);
        end
        bus.cpu_address = bus.cpu_address + 16'd1;
        bus.cpu_data    = bus.cpu_data + 16'd1;
        if (grants == 4) bus.cpu_req = 1'b0;
      end
      clear_overflow = 1'b0;
      gen_drive(1'b1);
    end
    n_checks++;
    if (grants != 4) begin
      n_fail++;
      $display("FAIL ovf_timeout: got %0d grants, want 4", grants);
    end
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, want 0", overflow);
    end
    gen_drive(1'b0);
    repeat (8) next_cycle();
    n_checks++;
    if (fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL ovf_drain: got %0d, want 0", fifo_level);
    end
    found = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i] >= 16'h8000 && obs_q[i] < 16'h8000 + 16'(sent)) found++;
    end
    n_checks++;
    if (found != sent - 1) begin
      n_fail++;
      $display("FAIL ovf_missing: got %0d of %0d gen writes, want %0d", found, sent, sent - 1);
    end
  endtask

  task automatic test_reset_midstream();
    bit reached;
    reached = 1'b0;
    gen_next = 16'hA000;
    gen_drive(1'b1);
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h0D00; bus.cpu_data = 16'h7777;
    for (int i = 0; i < 20 && !reached; i++) begin
      next_cycle();
      gen_drive(1'b1);
      if (fifo_level == 3'd2) begin
        reached = 1'b1;
        bus.cpu_req = 1'b0;
      end
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL rst_setup: got level %0d, want 2", fifo_level);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    bus.gen_load = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_load !== 1'b0 || bus.mem_address !== 16'h0 || bus.mem_data !== 16'h0 ||
        overflow !== 1'b0 || fifo_level !== 3'd0 || bus.cpu_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got load=%b addr=%h data=%h ovf=%b lvl=%0d gnt=%b, want all 0",
               bus.mem_load, bus.mem_address, bus.mem_data, overflow, fifo_level, bus.cpu_gnt);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_load !== 1'b0 || fifo_level !== 3'd0) begin
        n_fail++;
        $display("FAIL rst_stale[%0d]: got load=%b lvl=%0d, want 0/0", i, bus.mem_load, fifo_level);
      end
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_gen();
    test_cpu_alone();
    test_back_to_back();
    test_starvation();
    test_overflow();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

endmodule
